// File: rtl/controle_exibicao_sequencia.sv
// Timed sequencer that plays the stored round sequence on the game LEDs.
// It walks RAM entries 0..limite and lights each for T_ON cycles, then blanks for T_OFF cycles.
module controle_exibicao_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'b000,
        CARREGA = 3'b001,
        LE      = 3'b010,
        MOSTRA  = 3'b011,
        APAGADO = 3'b100,
        PROXIMO = 3'b101,
        FIM     = 3'b110
    } estado_t;

    localparam int T_MAX   = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TIMER_W = $clog2(T_MAX + 1);
    localparam logic [TIMER_W-1:0] ON_ULTIMO  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] OFF_ULTIMO = TIMER_W'(T_OFF - 1);

    estado_t             state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0]   endereco_q, endereco_d;
    logic [ADDR_W-1:0]   limite_q, limite_d;
    logic [DATA_W-1:0]   leds_q, leds_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;

    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        leds_d     = leds_q;

        case (state_q)
            OCIOSO: begin
                if (iniciar && !abortar) begin
                    limite_d   = limite;
                    endereco_d = '0;
                    state_d    = CARREGA;
                end
            end
            CARREGA: state_d = LE;
            LE: begin
                leds_d  = dado_memoria;
                state_d = MOSTRA;
            end
            MOSTRA: begin
                if (timer_q == ON_ULTIMO) begin
                    timer_d = '0;
                    leds_d  = '0;
                    state_d = APAGADO;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            APAGADO: begin
                if (timer_q == OFF_ULTIMO) begin
                    timer_d = '0;
                    state_d = PROXIMO;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            PROXIMO: begin
                // The last entry never increments, so limite = all-ones cannot wrap to 0.
                if (endereco_q == limite_q) begin
                    state_d = FIM;
                end else begin
                    endereco_d = endereco_q + ADDR_W'(1);
                    state_d    = CARREGA;
                end
            end
            FIM: state_d = OCIOSO;
            default: begin
                state_d = OCIOSO;
                timer_d = '0;
                leds_d  = '0;
            end
        endcase

        if (abortar && state_q != OCIOSO) begin
            state_d    = OCIOSO;
            timer_d    = '0;
            leds_d     = '0;
            endereco_d = endereco_q;
        end

        // Flags are decoded from the next state so they leave the flops aligned with db_estado.
        ocupado_d = (state_d != OCIOSO);
        pronto_d  = (state_d == FIM);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= OCIOSO;
            timer_q    <= '0;
            endereco_q <= '0;
            limite_q   <= '0;
            leds_q     <= '0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            leds_q     <= leds_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign endereco  = endereco_q;
    assign leds      = leds_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// Scoreboard bench for controle_exibicao_sequencia with T_ON=4, T_OFF=2 (9 cycles per entry).
module tb_controle_exibicao_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int PER   = 3 + T_ON + T_OFF;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] word;
    } show_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       abortar = 1'b0;
    logic [3:0] limite = '0;
    logic [3:0] dado_memoria = '0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    logic [3:0] mem [16];
    show_t      exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         prev_st = 0;
    int         on_cnt = 0;
    int         off_cnt = 0;

    controle_exibicao_sequencia #(
        .ADDR_W(4), .DATA_W(4), .T_ON(T_ON), .T_OFF(T_OFF)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
        .limite(limite), .dado_memoria(dado_memoria), .endereco(endereco),
        .leds(leds), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM model: data valid one cycle after the address.
    always @(posedge clock) dado_memoria <= mem[endereco];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Display monitor: pops the expected entry when a new MOSTRA begins and checks phase lengths.
    always @(negedge clock) begin
        show_t e;
        if (!reset) begin
            prev_st = 0;
            on_cnt  = 0;
            off_cnt = 0;
        end else begin
            if (db_estado == 3'd3) begin
                if (prev_st != 3) begin
                    if (exp_q.size() == 0) begin
                        check("show_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("show_addr", 32'(endereco), 32'(e.addr));
                        check("show_leds", 32'(leds), 32'(e.word));
                    end
                    on_cnt = 1;
                end else begin
                    on_cnt++;
                end
            end else if (prev_st == 3 && db_estado == 3'd4) begin
                check("t_on", 32'(on_cnt), 32'(T_ON));
            end
            if (db_estado == 3'd4) begin
                off_cnt = (prev_st == 4) ? off_cnt + 1 : 1;
            end else if (prev_st == 4 && db_estado == 3'd5) begin
                check("t_off", 32'(off_cnt), 32'(T_OFF));
            end
            if (db_estado >= 3'd4) check("leds_dark", 32'(leds), 32'd0);
            prev_st = int'(db_estado);
        end
    end

    task automatic push_entries(input int lim);
        for (int i = 0; i <= lim; i++) exp_q.push_back('{addr: 4'(i), word: mem[i]});
    endtask

    // Full run from OCIOSO; called right after a negedge. disturb pulses iniciar with limite=5 mid-run.
    task automatic run_seq(input int lim, input bit disturb);
        int last_e;
        int pronto_n;
        last_e   = (lim + 1) * PER;
        pronto_n = 0;
        push_entries(lim);
        limite  = 4'(lim);
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        for (int e = 1; e <= last_e + 4; e++) begin
            @(posedge clock);
            @(negedge clock);
            check("ocupado", 32'(ocupado), 32'(e <= last_e));
            if (e == 1) check("dark_before_show", 32'(leds), 32'd0);
            if (e == 2) check("first_show", 32'(leds), 32'(mem[0]));
            if (pronto) begin
                pronto_n++;
                check("pronto_edge", 32'(e), 32'(last_e));
            end
            if (disturb && (e == 5 || e == 12)) begin
                iniciar = 1'b1;
                limite  = 4'd5;
            end else begin
                iniciar = 1'b0;
                limite  = 4'(lim);
            end
        end
        check("pronto_count", 32'(pronto_n), 32'd1);
        check("end_addr", 32'(endereco), 32'(lim));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pronto_n;
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);

        // Reset state
        #1;
        check("rst_estado", 32'(db_estado), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_endereco", 32'(endereco), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 1: single entry
        mem[0] = 4'b0001;
        run_seq(0, 1'b0);

        // 2: three entries
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        run_seq(2, 1'b0);

        // 3: full memory, no address wrap
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        run_seq(15, 1'b0);

        // 4: abort during the second MOSTRA, then restart without reset
        push_entries(3);
        limite  = 4'd3;
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (e == 12) abortar = 1'b1;
        end
        check("abort_estado", 32'(db_estado), 32'd0);
        check("abort_leds", 32'(leds), 32'd0);
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_endereco", 32'(endereco), 32'd1);
        check("abort_pending", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        abortar  = 1'b0;
        pronto_n = 0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clock);
            if (pronto) pronto_n++;
        end
        check("abort_no_pronto", 32'(pronto_n), 32'd0);
        mem[0] = 4'b1000;
        run_seq(0, 1'b0);

        // 5: iniciar while busy with a new limite is ignored; abort beats iniciar in OCIOSO
        mem[0] = 4'b0101; mem[1] = 4'b1010;
        run_seq(1, 1'b1);
        iniciar = 1'b1;
        abortar = 1'b1;
        @(negedge clock);
        check("abort_wins_estado", 32'(db_estado), 32'd0);
        check("abort_wins_ocupado", 32'(ocupado), 32'd0);
        iniciar = 1'b0;
        abortar = 1'b0;
        @(negedge clock);

        // 6: asynchronous reset during the second APAGADO
        push_entries(1);
        limite  = 4'd1;
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("pre_reset_estado", 32'(db_estado), 32'd4);
        #1 reset = 1'b0;
        #1;
        check("async_estado", 32'(db_estado), 32'd0);
        check("async_leds", 32'(leds), 32'd0);
        check("async_ocupado", 32'(ocupado), 32'd0);
        check("async_pronto", 32'(pronto), 32'd0);
        check("async_endereco", 32'(endereco), 32'd0);
        check("async_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
